// File: rtl/isqrt_pkg.sv
// isqrt_pkg: shared FSM states and width helpers for the square-root engine
package isqrt_pkg;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  function automatic int rw_of(input int w);
    return w / 2;
  endfunction
  function automatic int cnt_w_of(input int w);
    return $clog2(w / 2);
  endfunction
endpackage

// File: rtl/isqrt_step.sv
// isqrt_step: one combinational bit-pair iteration of the digit-by-digit root
module isqrt_step #(
  parameter int RW = 8
) (
  input  logic [RW+1:0] rem,
  input  logic [RW-1:0] root,
  input  logic [1:0]    pair,
  output logic [RW+1:0] rem_n,
  output logic [RW-1:0] root_n
);
  logic [RW+1:0] rem_s, trial;
  logic ge;
  always_comb begin
    rem_s  = (rem << 2) | {{RW{1'b0}}, pair};
    trial  = {root, 2'b01};
    ge     = rem_s >= trial;
    rem_n  = ge ? rem_s - trial : rem_s;
    root_n = (root << 1) | {{(RW-1){1'b0}}, ge};
  end
endmodule

// File: rtl/isqrt_unit.sv
// isqrt_unit: sequential floor/round integer square root with start/ack handshake
module isqrt_unit import isqrt_pkg::*; #(
  parameter int W = 16,
  localparam int RW = rw_of(W)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          Round,
  input  logic [W-1:0]  Operand,
  output logic [RW-1:0] Root,
  output logic [RW:0]   Rem,
  output logic          Busy,
  output logic          Ack
);
  localparam int CW = cnt_w_of(W);
  state_t state, state_d;
  logic [W-1:0] opnd;
  logic [CW-1:0] cnt;
  logic rnd, launch;
  logic [RW-1:0] root, root_n, root_fix;
  logic [RW+1:0] rem, rem_n;
  isqrt_step #(.RW(RW)) u_step (
    .rem(rem),
    .root(root),
    .pair(opnd[W-1:W-2]),
    .rem_n(rem_n),
    .root_n(root_n)
  );
  always_comb begin
    launch   = Start && (state == IDLE || state == DONE);
    state_d  = launch ? CALC :
               state == CALC ? (cnt == '0 ? FIX : CALC) :
               state == FIX ? DONE : state;
    // round up when Operand lies past root^2 + root, never beyond all-ones
    root_fix = (rnd && rem > {2'b00, root} && !(&root)) ? root + RW'(1) : root;
  end
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else state <= state_d;
  end
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      opnd <= '0;
      cnt  <= '0;
      rnd  <= 1'b0;
      root <= '0;
      rem  <= '0;
    end else if (launch) begin
      opnd <= Operand;
      rnd  <= Round;
      root <= '0;
      rem  <= '0;
      cnt  <= CW'(RW - 1);
    end else if (state == CALC) begin
      opnd <= opnd << 2;
      root <= root_n;
      rem  <= rem_n;
      cnt  <= cnt - CW'(1);
    end else if (state == FIX) begin
      root <= root_fix;
    end
  end
  assign Root = root;
  assign Rem  = rem[RW:0];
  assign Busy = state == CALC || state == FIX;
  assign Ack  = state == DONE;
endmodule

// File: tb/tb_isqrt_unit.sv
// tb_isqrt_unit: directed and reference-model checks of isqrt_unit at W=16 and W=32
module tb_isqrt_unit;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic s16 = 1'b0, rd16 = 1'b0, s32 = 1'b0, rd32 = 1'b0;
  logic [15:0] op16 = '0;
  logic [31:0] op32 = '0;
  logic [7:0] root16;
  logic [8:0] rem16;
  logic [15:0] root32;
  logic [16:0] rem32;
  logic busy16, ack16, busy32, ack32;
  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  isqrt_unit #(.W(16)) dut16 (
    .Clk(Clk), .Reset(Reset), .Start(s16), .Round(rd16), .Operand(op16),
    .Root(root16), .Rem(rem16), .Busy(busy16), .Ack(ack16)
  );
  isqrt_unit #(.W(32)) dut32 (
    .Clk(Clk), .Reset(Reset), .Start(s32), .Round(rd32), .Operand(op32),
    .Root(root32), .Rem(rem32), .Busy(busy32), .Ack(ack32)
  );

  function automatic longint isqrt_ref(input longint x);
    longint lo = 0, hi = 65535, mid;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= x) lo = mid;
      else hi = mid - 1;
    end
    return lo;
  endfunction

  task automatic run16(input logic [15:0] op, input logic r, output int lat, output logic b);
    @(negedge Clk);
    s16 = 1'b1; op16 = op; rd16 = r;
    @(posedge Clk);
    #1 s16 = 1'b0; op16 = 16'h5a5a; rd16 = ~r;
    b = busy16;
    lat = 0;
    while (!ack16 && lat < 50) begin
      @(posedge Clk);
      #1 lat++;
    end
  endtask

  task automatic run32(input logic [31:0] op, input logic r, output int lat);
    @(negedge Clk);
    s32 = 1'b1; op32 = op; rd32 = r;
    @(posedge Clk);
    #1 s32 = 1'b0; op32 = ~op;
    lat = 0;
    while (!ack32 && lat < 60) begin
      @(posedge Clk);
      #1 lat++;
    end
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if ({root16, rem16, busy16, ack16} !== 19'd0) begin
      errors++;
      $display("FAIL reset16: root=%0d rem=%0d busy=%b ack=%b, required all 0", root16, rem16, busy16, ack16);
    end
    checks++;
    if ({root32, rem32, busy32, ack32} !== 35'd0) begin
      errors++;
      $display("FAIL reset32: root=%0d rem=%0d busy=%b ack=%b, required all 0", root32, rem32, busy32, ack32);
    end
    @(negedge Clk) Reset = 1'b0;
  endtask

  task automatic test_floor;
    int lat; logic b;
    run16(16'd190, 1'b0, lat, b);
    checks++;
    if (b !== 1'b1) begin errors++; $display("FAIL floor190_busy: busy=%b, required 1", b); end
    checks++;
    if (lat !== 9) begin errors++; $display("FAIL floor190_latency: %0d, required 9", lat); end
    checks++;
    if (root16 !== 8'd13 || rem16 !== 9'd21) begin
      errors++; $display("FAIL floor190: root=%0d rem=%0d, required 13 21", root16, rem16);
    end
    checks++;
    if (busy16 !== 1'b0) begin errors++; $display("FAIL floor190_busy_done: busy=%b, required 0", busy16); end
  endtask

  task automatic test_round;
    int lat; logic b;
    run16(16'd190, 1'b1, lat, b);
    checks++;
    if (root16 !== 8'd14 || rem16 !== 9'd21 || lat !== 9) begin
      errors++; $display("FAIL round190: root=%0d rem=%0d lat=%0d, required 14 21 9", root16, rem16, lat);
    end
    run16(16'd169, 1'b1, lat, b);
    checks++;
    if (root16 !== 8'd13 || rem16 !== 9'd0) begin
      errors++; $display("FAIL round169: root=%0d rem=%0d, required 13 0", root16, rem16);
    end
    run16(16'd20, 1'b1, lat, b);
    checks++;
    if (root16 !== 8'd4 || rem16 !== 9'd4) begin
      errors++; $display("FAIL round20: root=%0d rem=%0d, required 4 4", root16, rem16);
    end
  endtask

  task automatic test_extremes;
    int lat; logic b;
    run16(16'hffff, 1'b0, lat, b);
    checks++;
    if (root16 !== 8'd255 || rem16 !== 9'd510) begin
      errors++; $display("FAIL max_floor: root=%0d rem=%0d, required 255 510", root16, rem16);
    end
    run16(16'hffff, 1'b1, lat, b);
    checks++;
    if (root16 !== 8'd255 || rem16 !== 9'd510) begin
      errors++; $display("FAIL max_round_sat: root=%0d rem=%0d, required 255 510", root16, rem16);
    end
    run16(16'd0, 1'b1, lat, b);
    checks++;
    if (root16 !== 8'd0 || rem16 !== 9'd0 || lat !== 9) begin
      errors++; $display("FAIL zero: root=%0d rem=%0d lat=%0d, required 0 0 9", root16, rem16, lat);
    end
  endtask

  task automatic test_reset_mid;
    int lat; logic b;
    @(negedge Clk);
    s16 = 1'b1; op16 = 16'd190; rd16 = 1'b0;
    @(posedge Clk);
    #1 s16 = 1'b0;
    repeat (4) @(posedge Clk);
    #2 Reset = 1'b1;
    #1;
    checks++;
    if ({root16, rem16, busy16, ack16} !== 19'd0) begin
      errors++; $display("FAIL reset_mid: root=%0d rem=%0d busy=%b ack=%b, required all 0", root16, rem16, busy16, ack16);
    end
    @(negedge Clk) Reset = 1'b0;
    run16(16'd144, 1'b0, lat, b);
    checks++;
    if (root16 !== 8'd12 || rem16 !== 9'd0 || lat !== 9) begin
      errors++; $display("FAIL after_reset144: root=%0d rem=%0d lat=%0d, required 12 0 9", root16, rem16, lat);
    end
  endtask

  task automatic test_start_ignored;
    int lat;
    @(negedge Clk);
    s16 = 1'b1; op16 = 16'd190; rd16 = 1'b0;
    @(posedge Clk);
    #1 s16 = 1'b0;
    lat = 0;
    repeat (3) begin @(posedge Clk); #1 lat++; end
    s16 = 1'b1; op16 = 16'd9; rd16 = 1'b1;
    @(posedge Clk);
    #1 lat++; s16 = 1'b0;
    while (!ack16 && lat < 50) begin @(posedge Clk); #1 lat++; end
    checks++;
    if (root16 !== 8'd13 || rem16 !== 9'd21 || lat !== 9) begin
      errors++; $display("FAIL start_in_calc: root=%0d rem=%0d lat=%0d, required 13 21 9", root16, rem16, lat);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    @(negedge Clk);
    s16 = 1'b1; op16 = 16'd64; rd16 = 1'b0;
    @(posedge Clk);
    #1 op16 = 16'd100;
    lat = 0;
    while (!ack16 && lat < 50) begin @(posedge Clk); #1 lat++; end
    checks++;
    if (root16 !== 8'd8 || lat !== 9) begin
      errors++; $display("FAIL b2b_first: root=%0d lat=%0d, required 8 9", root16, lat);
    end
    @(posedge Clk);
    #1;
    checks++;
    if (ack16 !== 1'b0 || busy16 !== 1'b1) begin
      errors++; $display("FAIL b2b_relaunch: ack=%b busy=%b, required 0 1", ack16, busy16);
    end
    s16 = 1'b0;
    lat = 0;
    while (!ack16 && lat < 50) begin @(posedge Clk); #1 lat++; end
    checks++;
    if (root16 !== 8'd10 || rem16 !== 9'd0 || lat !== 9) begin
      errors++; $display("FAIL b2b_second: root=%0d rem=%0d lat=%0d, required 10 0 9", root16, rem16, lat);
    end
    repeat (3) @(posedge Clk);
    #1;
    checks++;
    if (ack16 !== 1'b1 || root16 !== 8'd10) begin
      errors++; $display("FAIL hold_done: ack=%b root=%0d, required 1 10", ack16, root16);
    end
  endtask

  task automatic test_w32;
    int lat;
    run32(32'hffff_ffff, 1'b0, lat);
    checks++;
    if (root32 !== 16'd65535 || rem32 !== 17'd131070 || lat !== 17) begin
      errors++; $display("FAIL w32_max: root=%0d rem=%0d lat=%0d, required 65535 131070 17", root32, rem32, lat);
    end
  endtask

  task automatic test_random;
    int lat;
    logic [31:0] x;
    logic r;
    longint fr, rr, rm;
    for (int i = 0; i < 1000; i++) begin
      x = $urandom;
      if (i % 4 == 1) x = x >> $urandom_range(31, 1);
      r = 1'($urandom_range(1, 0));
      fr = isqrt_ref({32'd0, x});
      rm = {32'd0, x} - fr * fr;
      rr = (r && rm > fr && fr != 65535) ? fr + 1 : fr;
      run32(x, r, lat);
      checks++;
      if (root32 !== 16'(rr) || rem32 !== 17'(rm) || lat !== 17) begin
        errors++;
        $display("FAIL rand32 x=%0d round=%b: root=%0d rem=%0d lat=%0d, required %0d %0d 17", x, r, root32, rem32, lat, rr, rm);
      end
    end
  endtask

  initial begin
    test_reset;
    test_floor;
    test_round;
    test_extremes;
    test_reset_mid;
    test_start_ignored;
    test_back_to_back;
    test_w32;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/isqrt_unit.md
# isqrt_unit

- Parametrised sequential integer square-root engine with a start/ack handshake.
- Computes floor or round-to-nearest root of a W-bit unsigned operand, one result bit per clock, using the bit-pair (digit-by-digit) method. Also returns the floor remainder.
- Sits beside the CPU datapath as a coprocessor: offloads the Program 3 square root and generalises it beyond 16-bit operands.

## Interface

Parameters:
- W, 16, operand width; must be even and ≥ 4.
- RW, W/2, root width (derived; not overridden).

Ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  launch request; sampled in IDLE and DONE only.
- Round  in  1  mode, sampled with Start: 0 = floor, 1 = round-to-nearest (saturating).
- Operand  in  W  unsigned radicand, sampled with Start.
- Root  out  RW  result root, valid while Ack=1.
- Rem  out  RW+1  floor remainder (Operand − floor_root²), valid while Ack=1.
- Busy  out  1  high in CALC and FIX.
- Ack  out  1  high in DONE ("program run complete").

## Operation

- Reset values: state IDLE; Root=0, Rem=0, Busy=0, Ack=0; internal operand shift register, counter and mode flag all 0.
- States:
  - IDLE: Start=1 → capture Operand into shift register, capture Round, clear root/rem accumulators, load counter=RW−1, go to CALC.
  - CALC: one iteration per cycle, then decrement the counter. Counter=0 at the iteration edge → FIX.
  - FIX: apply the rounding rule, then → DONE.
  - DONE: hold Root/Rem/Ack. Start=1 → same capture as IDLE, go to CALC; Ack drops on that edge.
- Iteration (widths RW+2 internal for rem):
  - rem' = (rem<<2) | top two operand bits; operand shifts left by 2.
  - trial = (root<<2) | 1.
  - If rem' ≥ trial: rem = rem' − trial, root = (root<<1)|1. Else: rem = rem', root = root<<1.
- Rounding in FIX, only when the captured Round=1:
  - If rem > root and root ≠ all-ones: root+1.
  - If root = all-ones: saturate at all-ones.
  - Rem always reports the floor remainder; it is never adjusted.
- Arithmetic is fully unsigned; no overflow exists because rem ≤ 2·root < 2^(RW+1).
- Start during CALC/FIX is ignored. Operand and Round changes after capture have no effect.
- Operand=0 needs no special case: result Root=0, Rem=0.
- Reset asserted mid-operation aborts immediately to the reset values. There is no partial Ack.

## Timing

- Start seen high at rising edge k (state IDLE or DONE): Busy=1 from k, Ack=1 from edge k+RW+1 onward.
  - W=16: Ack rises 9 cycles after the Start edge.
- Ack and results persist until the next accepted Start or Reset. Start may be held high across several cycles: it relaunches only from DONE. Holding Start continuously therefore repeats the computation back-to-back.
- Root/Rem are registered outputs. No combinational path from any input to any output.
- Throughput: one result per RW+1 cycles.

## Structure

- Package isqrt_pkg:
  - state enum (IDLE, CALC, FIX, DONE);
  - localparam helpers for RW and the counter width ($clog2(RW)).
- Sub-module isqrt_step: purely combinational single iteration. Inputs rem, root, operand bit pair; outputs next rem and next root. Instantiated once and parametrised by RW.
- Top module holds the FSM, counter, shift register and output registers.

## Test plan

- W=16, Operand=190, Round=0 → Root=13 (0x0D), Rem=21; Ack 9 cycles after Start edge.
- W=16, Operand=190, Round=1 → Root=14, Rem=21. Operand=169, Round=1 → Root=13, Rem=0.
- W=16, Operand=65535:
  - Round=0 → Root=255, Rem=510.
  - Round=1 → Root=255 (saturation), Rem=510.
  - Operand=0 → Root=0, Rem=0.
- Reset pulsed 4 cycles into CALC → Root=0, Rem=0, Busy=0, Ack=0 immediately. A subsequent Start with Operand=144 → Root=12, Ack after 9 cycles.
- Start re-asserted during CALC is ignored (result unchanged, latency unchanged). Start held high through DONE → new operand 100 accepted, Ack low for 9 cycles, then Root=10.
- W=32, Operand=0xFFFFFFFF, Round=0 → Root=65535, Rem=131070; Ack 17 cycles after Start. Randomised 1000 operands are checked against a reference floor(sqrt) model.
